// File: rtl/fetch_unit_pkg.sv
// Shared pipeline types and widths for the fetch stage and its consumers.
package fetch_unit_pkg;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus4;
  } if_id_t;
endpackage

// File: rtl/fetch_unit_pc_gen.sv
// PC generator: owns fetch_pc and the in-flight request, drives the cache address.
module fetch_unit_pc_gen
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [PC_W-1:0] PC_STEP  = 32'd4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] cache_addr,
  output logic [PC_W-1:0] req_pc,
  output logic            req_valid
);
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] target;

  assign target = {redirect_pc[PC_W-1:2], 2'b00};

  // Stall replays the in-flight address so next cycle's data still matches req_pc.
  always_comb begin
    cache_addr = fetch_pc;
    if (redirect_valid)  cache_addr = target;
    else if (id_stall)   cache_addr = req_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      req_pc    <= '0;
      req_valid <= 1'b0;
    end else if (redirect_valid) begin
      req_pc    <= target;
      req_valid <= 1'b1;
      fetch_pc  <= target + PC_STEP;
    end else if (!id_stall) begin
      req_pc    <= fetch_pc;
      req_valid <= 1'b1;
      fetch_pc  <= fetch_pc + PC_STEP;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, IF/ID capture, misalign flag, delivery counter.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [PC_W-1:0] PC_STEP  = 32'd4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    iCacheReadAddr,
  input  logic [INSTR_W-1:0] iCacheReadData,
  input  logic               id_stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [PC_W-1:0]    if_id_pc_plus4,
  output logic               misalign_err,
  output logic [31:0]        fetch_count
);
  logic [PC_W-1:0] req_pc;
  logic            req_valid;
  if_id_t          if_id_q;

  fetch_unit_pc_gen #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc_gen (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .cache_addr     (iCacheReadAddr),
    .req_pc         (req_pc),
    .req_valid      (req_valid)
  );

  // A redirect only clears valid; the stale payload is harmless once flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_q      <= '0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else if (redirect_valid) begin
      if_id_q.valid <= 1'b0;
      if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
    end else if (!id_stall) begin
      if_id_q.valid    <= req_valid;
      if_id_q.instr    <= iCacheReadData;
      if_id_q.pc       <= req_pc;
      if_id_q.pc_plus4 <= req_pc + PC_STEP;
      if (req_valid) fetch_count <= fetch_count + 32'd1;
    end
  end

  assign if_id_valid    = if_id_q.valid;
  assign if_id_instr    = if_id_q.instr;
  assign if_id_pc       = if_id_q.pc;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed test-plan steps then random stall/redirect traffic.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] iCacheReadAddr, iCacheReadData;
  logic        id_stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid, misalign_err;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count;

  int vectors = 0;
  int miscompares = 0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .iCacheReadAddr(iCacheReadAddr), .iCacheReadData(iCacheReadData),
    .id_stall(id_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4), .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001000f;
    if (a == 32'h4) return 32'h08000008;
    return a ^ {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // Synchronous cache: data next cycle reflects the address driven this cycle.
  always @(posedge clk) iCacheReadData <= mem(iCacheReadAddr);

  // Reference model as a stream: next PC to deliver, plus a pending
  // startup bubble (one non-stalled edge yields nothing after reset).
  logic [31:0] m_next, m_instr, m_pc, m_count;
  logic        m_valid, m_bubble, m_mis;

  task automatic model_reset();
    m_next = 32'h0; m_bubble = 1'b1; m_valid = 1'b0;
    m_instr = '0; m_pc = '0; m_count = '0; m_mis = 1'b0;
  endtask

  function automatic logic [31:0] exp_addr(input bit s, input bit r, input logic [31:0] rp);
    if (r) return {rp[31:2], 2'b00};
    if (s) return m_bubble ? 32'h0 : m_next;
    return m_bubble ? m_next : m_next + 32'd4;
  endfunction

  task automatic model_edge(input bit s, input bit r, input logic [31:0] rp);
    if (r) begin
      m_valid = 1'b0; m_bubble = 1'b0;
      m_next  = {rp[31:2], 2'b00};
      if (rp[1:0] != 2'b00) m_mis = 1'b1;
    end else if (!s) begin
      if (m_bubble) begin
        m_bubble = 1'b0; m_valid = 1'b0;
      end else begin
        m_valid = 1'b1; m_pc = m_next; m_instr = mem(m_next);
        m_next  = m_next + 32'd4; m_count = m_count + 32'd1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("instr", if_id_instr, m_instr);
      chk("pc", if_id_pc, m_pc);
      chk("pc_plus4", if_id_pc_plus4, m_pc + 32'd4);
    end
    chk("count", fetch_count, m_count);
    chk("misalign", {31'b0, misalign_err}, {31'b0, m_mis});
  endtask

  task automatic check_reset_state();
    chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc", if_id_pc, 32'h0);
    chk("rst_pc4", if_id_pc_plus4, 32'h0);
    chk("rst_mis", {31'b0, misalign_err}, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_addr", iCacheReadAddr, 32'h0);
  endtask

  // Called just after a negedge; returns just after the following negedge.
  task automatic step(input bit s, input bit r, input logic [31:0] rp);
    id_stall = s; redirect_valid = r; redirect_pc = rp;
    #1 chk("addr", iCacheReadAddr, exp_addr(s, r, rp));
    @(posedge clk);
    model_edge(s, r, rp);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst_n = 1'b0; id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    model_reset();
    #2 check_reset_state();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset release, sequential fetch of 0 and 4.
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    // Stall three cycles with pc 4 held, then resume at pc 8.
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    step(0, 0, 0); step(0, 0, 0);
    // Redirect to 0x20, bubble, then target.
    step(0, 1, 32'h20); step(0, 0, 0); step(0, 0, 0);
    // Redirect together with stall: redirect wins.
    step(1, 1, 32'h40); step(0, 0, 0); step(0, 0, 0);
    // Stall inside the bubble after a redirect.
    step(0, 1, 32'h60); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    // Misaligned target: aligned fetch, sticky flag.
    step(0, 1, 32'h22); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    // Wrap across the top of the address space.
    step(0, 1, 32'hFFFF_FFF8); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      bit s, r;
      logic [31:0] rp;
      if (i == 200) begin
        // Async reset mid-stream, asserted away from the clock edge.
        id_stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h44;
        #2 rst_n = 1'b0;
        id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        #1 check_reset_state();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      s  = ($urandom_range(0, 99) < 30);
      r  = ($urandom_range(0, 99) < 12);
      rp = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                       : ($urandom & 32'h0000_01FF);
      step(s, r, rp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
